// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the fetch requester, load requester and ROM port signals
// of mem_arbiter. The master modport is the arbiter's view; the slave modport is
// the view of the surrounding fetch/load units and ROM.
// MEM_DEPTH and MEM_EXTRA must match the parameters of the connected arbiter.
interface mem_arbiter_if #(
    parameter int MEM_DEPTH = 3,
    parameter int MEM_EXTRA = 4
);
    localparam int DW = (2 ** MEM_EXTRA) * 8;

    // Fetch requester
    logic                 fetch_req;
    logic [MEM_DEPTH:0]   fetch_addr;
    logic [MEM_EXTRA-1:0] fetch_extra;
    logic                 fetch_gnt;
    logic                 fetch_valid;
    logic [DW-1:0]        fetch_data;
    logic                 fetch_error;

    // Load requester
    logic                 load_req;
    logic [MEM_DEPTH:0]   load_addr;
    logic [MEM_EXTRA-1:0] load_extra;
    logic                 load_gnt;
    logic                 load_valid;
    logic [DW-1:0]        load_data;
    logic                 load_error;

    // ROM port
    logic [MEM_DEPTH:0]   mem_addr;
    logic [MEM_EXTRA-1:0] mem_extra;
    logic [DW-1:0]        mem_data;
    logic                 mem_error;

    modport master (
        input  fetch_req, fetch_addr, fetch_extra,
        output fetch_gnt, fetch_valid, fetch_data, fetch_error,
        input  load_req, load_addr, load_extra,
        output load_gnt, load_valid, load_data, load_error,
        output mem_addr, mem_extra,
        input  mem_data, mem_error
    );

    modport slave (
        output fetch_req, fetch_addr, fetch_extra,
        input  fetch_gnt, fetch_valid, fetch_data, fetch_error,
        output load_req, load_addr, load_extra,
        input  load_gnt, load_valid, load_data, load_error,
        input  mem_addr, mem_extra,
        output mem_data, mem_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous ROM port between instruction fetch and data
// load. One access in flight at a time; request and response paths are registered.
// Optional feature macro MEM_ARB_RR_EN: when defined, ties are broken round-robin;
// when undefined, fetch has fixed priority over load.
module mem_arbiter #(
    parameter int MEM_DEPTH   = 3,
    parameter int MEM_EXTRA   = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t        state;
    logic          owner_load;
    logic [CW-1:0] cnt;
    logic          pick_load;

`ifdef MEM_ARB_RR_EN
    logic          last_load;

    // Round-robin: on a tie, the requester that was not granted last wins.
    always_comb begin
        pick_load = bus.load_req && (!bus.fetch_req || !last_load);
    end

    // Remember who won the latest grant; reset value makes fetch win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_load <= 1'b1;
        end else if (state == IDLE && (bus.fetch_req || bus.load_req)) begin
            last_load <= pick_load;
        end
    end
`else
    // Fixed priority: load only wins when fetch is not asking.
    always_comb begin
        pick_load = bus.load_req && !bus.fetch_req;
    end
`endif

    // Arbitration FSM with registered ROM request, grant pulses and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            owner_load      <= 1'b0;
            cnt             <= '0;
            bus.mem_addr    <= '0;
            bus.mem_extra   <= '0;
            bus.fetch_gnt   <= 1'b0;
            bus.fetch_valid <= 1'b0;
            bus.fetch_data  <= '0;
            bus.fetch_error <= 1'b0;
            bus.load_gnt    <= 1'b0;
            bus.load_valid  <= 1'b0;
            bus.load_data   <= '0;
            bus.load_error  <= 1'b0;
        end else begin
            bus.fetch_gnt   <= 1'b0;
            bus.load_gnt    <= 1'b0;
            bus.fetch_valid <= 1'b0;
            bus.load_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.fetch_req || bus.load_req) begin
                        if (pick_load) begin
                            bus.mem_addr  <= bus.load_addr;
                            bus.mem_extra <= bus.load_extra;
                            bus.load_gnt  <= 1'b1;
                            owner_load    <= 1'b1;
                        end else begin
                            bus.mem_addr  <= bus.fetch_addr;
                            bus.mem_extra <= bus.fetch_extra;
                            bus.fetch_gnt <= 1'b1;
                            owner_load    <= 1'b0;
                        end
                        cnt   <= CW'(MEM_LATENCY);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        if (owner_load) begin
                            bus.load_data   <= bus.mem_data;
                            bus.load_error  <= bus.mem_error;
                            bus.load_valid  <= 1'b1;
                        end else begin
                            bus.fetch_data  <= bus.mem_data;
                            bus.fetch_error <= bus.mem_error;
                            bus.fetch_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter. A default-latency
// instance and a MEM_LATENCY=3 instance share clock and reset; each has a ROM model
// returning zero-extended {mem_addr, mem_extra} with error for addresses above 4'hC.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   passCount  = 0;

    mem_arbiter_if #(.MEM_DEPTH(3), .MEM_EXTRA(4)) bus ();
    mem_arbiter_if #(.MEM_DEPTH(3), .MEM_EXTRA(4)) bus3 ();

    mem_arbiter #(.MEM_DEPTH(3), .MEM_EXTRA(4), .MEM_LATENCY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    mem_arbiter #(.MEM_DEPTH(3), .MEM_EXTRA(4), .MEM_LATENCY(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.master)
    );

    // Clock with a 10-unit period.
    always #5 clk = ~clk;

    // One-cycle registered ROM model for the default instance.
    always_ff @(posedge clk) begin
        bus.mem_data  <= {120'd0, bus.mem_addr, bus.mem_extra};
        bus.mem_error <= (bus.mem_addr > 4'hC);
    end

    // Three-cycle ROM model for the MEM_LATENCY=3 instance.
    logic [127:0] romStage1, romStage2;
    logic         errStage1, errStage2;
    always_ff @(posedge clk) begin
        romStage1      <= {120'd0, bus3.mem_addr, bus3.mem_extra};
        errStage1      <= (bus3.mem_addr > 4'hC);
        romStage2      <= romStage1;
        errStage2      <= errStage1;
        bus3.mem_data  <= romStage2;
        bus3.mem_error <= errStage2;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fReq, input logic [3:0] fAddr,
                                 input logic [3:0] fExtra, input logic lReq,
                                 input logic [3:0] lAddr, input logic [3:0] lExtra);
        bus.fetch_req   = fReq;
        bus.fetch_addr  = fAddr;
        bus.fetch_extra = fExtra;
        bus.load_req    = lReq;
        bus.load_addr   = lAddr;
        bus.load_extra  = lExtra;
    endtask

    // Advance to the middle of the next cycle (just after the falling edge).
    task automatic stepCycle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        bus3.fetch_req   = 1'b0;
        bus3.fetch_addr  = 4'h0;
        bus3.fetch_extra = 4'h0;
        bus3.load_req    = 1'b0;
        bus3.load_addr   = 4'h0;
        bus3.load_extra  = 4'h0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_fetch_gnt",   {127'd0, bus.fetch_gnt},   128'd0);
        checkOutput("rst_fetch_valid", {127'd0, bus.fetch_valid}, 128'd0);
        checkOutput("rst_load_valid",  {127'd0, bus.load_valid},  128'd0);
        checkOutput("rst_fetch_data",  bus.fetch_data,            128'd0);
        checkOutput("rst_mem_addr",    {124'd0, bus.mem_addr},    128'd0);
        reset = 1'b0;

        // 1: single fetch access
        applyStimulus(1'b1, 4'h4, 4'h3, 1'b0, 4'h0, 4'h0);
        stepCycle(1);
        checkOutput("t1_fetch_gnt", {127'd0, bus.fetch_gnt}, 128'd1);
        checkOutput("t1_mem_addr",  {124'd0, bus.mem_addr},  128'h4);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        stepCycle(1);
        checkOutput("t1_gnt_pulse",  {127'd0, bus.fetch_gnt},   128'd0);
        checkOutput("t1_valid_early", {127'd0, bus.fetch_valid}, 128'd0);
        stepCycle(1);
        checkOutput("t1_fetch_valid", {127'd0, bus.fetch_valid}, 128'd1);
        checkOutput("t1_fetch_data",  bus.fetch_data,            128'h43);
        checkOutput("t1_fetch_error", {127'd0, bus.fetch_error}, 128'd0);
        checkOutput("t1_load_valid",  {127'd0, bus.load_valid},  128'd0);
        checkOutput("t1_load_data",   bus.load_data,             128'd0);

        // 2: simultaneous requests, both held
        applyStimulus(1'b1, 4'h1, 4'h0, 1'b1, 4'h2, 4'h0);
        stepCycle(1);
        checkOutput("t2_fetch_gnt1", {127'd0, bus.fetch_gnt}, 128'd1);
        checkOutput("t2_load_gnt1",  {127'd0, bus.load_gnt},  128'd0);
        checkOutput("t2_mem_addr1",  {124'd0, bus.mem_addr},  128'h1);
        stepCycle(2);
        checkOutput("t2_fetch_valid", {127'd0, bus.fetch_valid}, 128'd1);
        checkOutput("t2_fetch_data",  bus.fetch_data,            128'h10);
        stepCycle(1);
`ifdef MEM_ARB_RR_EN
        checkOutput("t2_rr_load_gnt",  {127'd0, bus.load_gnt},  128'd1);
        checkOutput("t2_rr_fetch_gnt", {127'd0, bus.fetch_gnt}, 128'd0);
        checkOutput("t2_rr_mem_addr",  {124'd0, bus.mem_addr},  128'h2);
        bus.load_req = 1'b0;
        stepCycle(2);
        checkOutput("t2_rr_load_valid", {127'd0, bus.load_valid}, 128'd1);
        checkOutput("t2_rr_load_data",  bus.load_data,            128'h20);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        stepCycle(1);
`else
        checkOutput("t2_fp_fetch_gnt", {127'd0, bus.fetch_gnt}, 128'd1);
        checkOutput("t2_fp_load_gnt",  {127'd0, bus.load_gnt},  128'd0);
        stepCycle(2);
        checkOutput("t2_fp_fetch_valid", {127'd0, bus.fetch_valid}, 128'd1);
        bus.fetch_req = 1'b0;
        stepCycle(1);
        checkOutput("t2_fp_load_gnt2", {127'd0, bus.load_gnt}, 128'd1);
        checkOutput("t2_fp_mem_addr",  {124'd0, bus.mem_addr}, 128'h2);
        bus.load_req = 1'b0;
        stepCycle(2);
        checkOutput("t2_fp_load_valid", {127'd0, bus.load_valid}, 128'd1);
        checkOutput("t2_fp_load_data",  bus.load_data,            128'h20);
        stepCycle(1);
`endif

        // 3: load error flag forwarded, then cleared by a good address
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'hE, 4'h0);
        stepCycle(1);
        checkOutput("t3_load_gnt", {127'd0, bus.load_gnt}, 128'd1);
        bus.load_req = 1'b0;
        stepCycle(2);
        checkOutput("t3_load_valid_e", {127'd0, bus.load_valid}, 128'd1);
        checkOutput("t3_load_error_e", {127'd0, bus.load_error}, 128'd1);
        checkOutput("t3_load_data_e",  bus.load_data,            128'hE0);
        checkOutput("t3_fetch_data",   bus.fetch_data,           128'h10);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'h2, 4'h5);
        stepCycle(1);
        bus.load_req = 1'b0;
        stepCycle(2);
        checkOutput("t3_load_valid_ok", {127'd0, bus.load_valid}, 128'd1);
        checkOutput("t3_load_error_ok", {127'd0, bus.load_error}, 128'd0);
        checkOutput("t3_load_data_ok",  bus.load_data,            128'h25);

        // 4: load raised during fetch WAIT is held off until IDLE
        applyStimulus(1'b1, 4'h5, 4'h1, 1'b0, 4'h0, 4'h0);
        stepCycle(1);
        checkOutput("t4_fetch_gnt", {127'd0, bus.fetch_gnt}, 128'd1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'h3, 4'h2);
        stepCycle(1);
        checkOutput("t4_no_load_gnt_c2", {127'd0, bus.load_gnt}, 128'd0);
        stepCycle(1);
        checkOutput("t4_fetch_valid",    {127'd0, bus.fetch_valid}, 128'd1);
        checkOutput("t4_no_load_gnt_c3", {127'd0, bus.load_gnt},    128'd0);
        stepCycle(1);
        checkOutput("t4_load_gnt",  {127'd0, bus.load_gnt}, 128'd1);
        checkOutput("t4_mem_addr",  {124'd0, bus.mem_addr}, 128'h3);
        bus.load_req = 1'b0;
        stepCycle(2);
        checkOutput("t4_load_valid", {127'd0, bus.load_valid}, 128'd1);
        checkOutput("t4_load_data",  bus.load_data,            128'h32);

        // 5: reset in cycle 2 of an access drops it
        applyStimulus(1'b1, 4'h6, 4'h0, 1'b0, 4'h0, 4'h0);
        stepCycle(1);
        bus.fetch_req = 1'b0;
        stepCycle(1);
        reset = 1'b1;
        stepCycle(1);
        reset = 1'b0;
        checkOutput("t5_fetch_valid", {127'd0, bus.fetch_valid}, 128'd0);
        checkOutput("t5_fetch_data",  bus.fetch_data,            128'd0);
        checkOutput("t5_load_data",   bus.load_data,             128'd0);
        checkOutput("t5_mem_addr",    {124'd0, bus.mem_addr},    128'd0);
        stepCycle(1);
        checkOutput("t5_no_late_valid", {127'd0, bus.fetch_valid}, 128'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'h7, 4'h1);
        stepCycle(1);
        checkOutput("t5_load_gnt", {127'd0, bus.load_gnt}, 128'd1);
        bus.load_req = 1'b0;
        stepCycle(2);
        checkOutput("t5_load_valid", {127'd0, bus.load_valid}, 128'd1);
        checkOutput("t5_load_data",  bus.load_data,            128'h71);

        // 6: MEM_LATENCY=3 instance delivers valid in cycle 5
        bus3.fetch_req   = 1'b1;
        bus3.fetch_addr  = 4'h9;
        bus3.fetch_extra = 4'h4;
        stepCycle(1);
        checkOutput("t6_fetch_gnt", {127'd0, bus3.fetch_gnt}, 128'd1);
        bus3.fetch_req = 1'b0;
        stepCycle(3);
        checkOutput("t6_valid_c4", {127'd0, bus3.fetch_valid}, 128'd0);
        stepCycle(1);
        checkOutput("t6_valid_c5", {127'd0, bus3.fetch_valid}, 128'd1);
        checkOutput("t6_data",     bus3.fetch_data,            128'h94);
        checkOutput("t6_error",    {127'd0, bus3.fetch_error}, 128'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
